// File: rtl/gps_rmc_parser.sv
// gps_rmc_parser: NMEA RMC byte-stream parser. Extracts the latitude and
// longitude minute fields (mm.mmm -> mmmmm) and publishes them with a
// one-cycle data_en pulse once a fixed, checksum-correct sentence ends.
// Rejected RMC sentences (checksum or format error) give a parse_err pulse.
//
// Handshake: a byte is consumed on every clk edge where rx_valid=1; there is
// no backpressure, so strobes on consecutive cycles are all taken.
module gps_rmc_parser (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [16:0] wei_num,
    output logic [16:0] jing_num,
    output logic        data_en,
    output logic        parse_err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HDR   = 3'd1,
        S_FIELD = 3'd2,
        S_CK1   = 3'd3,
        S_CK2   = 3'd4
    } state_t;

    state_t      state_q;
    logic [2:0]  hdr_cnt_q;     // header characters captured so far (0..5)
    logic [7:0]  csum_q;        // running XOR of bytes between '$' and '*'
    logic [3:0]  fld_idx_q;     // current field index, saturates at 15
    logic        fld_first_q;   // next FIELD byte is the first of its field
    logic        fix_ok_q;
    logic [3:0]  ck_hi_q;       // first received checksum nibble

    // Coordinate accumulators: index 0 = latitude (field 3), 1 = longitude (field 5)
    logic [3:0]  tens_q  [2];
    logic [3:0]  units_q [2];
    logic [9:0]  frac_q  [2];
    logic [1:0]  fcnt_q  [2];   // fraction digits consumed, stops at 3
    logic        dot_q   [2];
    logic        int_q   [2];   // at least one integer digit seen
    logic        bad_q   [2];   // illegal character seen

    logic [16:0] wei_q;
    logic [16:0] jing_q;
    logic        data_en_q;
    logic        parse_err_q;

    // Byte classification and field-value arithmetic
    logic        is_digit;
    logic        is_hex;
    logic        is_crlf;
    logic [3:0]  hex_val;
    logic [7:0]  hdr_exp;
    logic        csel;
    logic        in_coord;
    logic [9:0]  frac_term;
    logic        ck_match;
    logic [1:0]  coord_ok;
    logic [16:0] coord_val [2];

    assign wei_num   = wei_q;
    assign jing_num  = jing_q;
    assign data_en   = data_en_q;
    assign parse_err = parse_err_q;

    // Decode the incoming byte and form the end-of-sentence coordinate values
    always_comb begin
        is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);
        is_crlf  = (rx_data == 8'h0D) || (rx_data == 8'h0A);
        is_hex   = is_digit;
        hex_val  = rx_data[3:0];
        if (((rx_data >= 8'h41) && (rx_data <= 8'h46)) ||
            ((rx_data >= 8'h61) && (rx_data <= 8'h66))) begin
            is_hex  = 1'b1;
            hex_val = rx_data[3:0] + 4'd9;
        end
        // Talker characters (positions 1-2) are free; positions 3-5 must be "RMC"
        case (hdr_cnt_q)
            3'd2:    hdr_exp = 8'h52;
            3'd3:    hdr_exp = 8'h4D;
            3'd4:    hdr_exp = 8'h43;
            default: hdr_exp = rx_data;
        endcase
        csel     = (fld_idx_q == 4'd5);
        in_coord = (fld_idx_q == 4'd3) || (fld_idx_q == 4'd5);
        case (fcnt_q[csel])
            2'd0:    frac_term = 10'(rx_data[3:0]) * 10'd100;
            2'd1:    frac_term = 10'(rx_data[3:0]) * 10'd10;
            default: frac_term = 10'(rx_data[3:0]);
        endcase
        ck_match     = ({ck_hi_q, hex_val} == csum_q);
        coord_ok[0]  = dot_q[0] && int_q[0] && !bad_q[0];
        coord_ok[1]  = dot_q[1] && int_q[1] && !bad_q[1];
        coord_val[0] = 17'(tens_q[0]) * 17'd10000 + 17'(units_q[0]) * 17'd1000 + 17'(frac_q[0]);
        coord_val[1] = 17'(tens_q[1]) * 17'd10000 + 17'(units_q[1]) * 17'd1000 + 17'(frac_q[1]);
    end

    // Sentence FSM, field accumulators and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            hdr_cnt_q   <= 3'd0;
            csum_q      <= 8'd0;
            fld_idx_q   <= 4'd0;
            fld_first_q <= 1'b0;
            fix_ok_q    <= 1'b0;
            ck_hi_q     <= 4'd0;
            tens_q[0]   <= 4'd0;  tens_q[1]  <= 4'd0;
            units_q[0]  <= 4'd0;  units_q[1] <= 4'd0;
            frac_q[0]   <= 10'd0; frac_q[1]  <= 10'd0;
            fcnt_q[0]   <= 2'd0;  fcnt_q[1]  <= 2'd0;
            dot_q[0]    <= 1'b0;  dot_q[1]   <= 1'b0;
            int_q[0]    <= 1'b0;  int_q[1]   <= 1'b0;
            bad_q[0]    <= 1'b0;  bad_q[1]   <= 1'b0;
            wei_q       <= 17'd0;
            jing_q      <= 17'd0;
            data_en_q   <= 1'b0;
            parse_err_q <= 1'b0;
        end else begin
            data_en_q   <= 1'b0;
            parse_err_q <= 1'b0;
            if (rx_valid) begin
                if (rx_data == 8'h24) begin
                    // '$' restarts from any state. Each field index is entered at
                    // most once per sentence, so clearing the accumulators here
                    // also clears them at the start of their field.
                    state_q     <= S_HDR;
                    hdr_cnt_q   <= 3'd0;
                    csum_q      <= 8'd0;
                    fld_idx_q   <= 4'd0;
                    fld_first_q <= 1'b0;
                    fix_ok_q    <= 1'b0;
                    ck_hi_q     <= 4'd0;
                    tens_q[0]   <= 4'd0;  tens_q[1]  <= 4'd0;
                    units_q[0]  <= 4'd0;  units_q[1] <= 4'd0;
                    frac_q[0]   <= 10'd0; frac_q[1]  <= 10'd0;
                    fcnt_q[0]   <= 2'd0;  fcnt_q[1]  <= 2'd0;
                    dot_q[0]    <= 1'b0;  dot_q[1]   <= 1'b0;
                    int_q[0]    <= 1'b0;  int_q[1]   <= 1'b0;
                    bad_q[0]    <= 1'b0;  bad_q[1]   <= 1'b0;
                end else begin
                    case (state_q)
                        S_HDR: begin
                            if (is_crlf) begin
                                // Only a complete RMC header makes the abort an error
                                state_q     <= S_IDLE;
                                parse_err_q <= (hdr_cnt_q == 3'd5);
                            end else if (hdr_cnt_q == 3'd5) begin
                                if (rx_data == 8'h2C) begin
                                    state_q     <= S_FIELD;
                                    csum_q      <= csum_q ^ rx_data;
                                    fld_idx_q   <= 4'd1;
                                    fld_first_q <= 1'b1;
                                end else begin
                                    state_q     <= S_IDLE;
                                    parse_err_q <= 1'b1;
                                end
                            end else begin
                                csum_q    <= csum_q ^ rx_data;
                                hdr_cnt_q <= hdr_cnt_q + 3'd1;
                                if (rx_data != hdr_exp) begin
                                    state_q <= S_IDLE;
                                end
                            end
                        end
                        S_FIELD: begin
                            if (is_crlf) begin
                                state_q     <= S_IDLE;
                                parse_err_q <= 1'b1;
                            end else if (rx_data == 8'h2A) begin
                                state_q <= S_CK1;
                            end else begin
                                csum_q <= csum_q ^ rx_data;
                                if (rx_data == 8'h2C) begin
                                    fld_first_q <= 1'b1;
                                    if (fld_idx_q != 4'd15) begin
                                        fld_idx_q <= fld_idx_q + 4'd1;
                                    end
                                end else begin
                                    fld_first_q <= 1'b0;
                                    // Status is good only when the field is exactly "A"
                                    if (fld_idx_q == 4'd2) begin
                                        fix_ok_q <= fld_first_q && (rx_data == 8'h41);
                                    end
                                    if (in_coord) begin
                                        if (is_digit) begin
                                            if (!dot_q[csel]) begin
                                                tens_q[csel]  <= units_q[csel];
                                                units_q[csel] <= rx_data[3:0];
                                                int_q[csel]   <= 1'b1;
                                            end else if (fcnt_q[csel] != 2'd3) begin
                                                frac_q[csel] <= frac_q[csel] + frac_term;
                                                fcnt_q[csel] <= fcnt_q[csel] + 2'd1;
                                            end
                                        end else if (rx_data == 8'h2E) begin
                                            dot_q[csel] <= 1'b1;
                                        end else begin
                                            bad_q[csel] <= 1'b1;
                                        end
                                    end
                                end
                            end
                        end
                        S_CK1: begin
                            if (is_hex && !is_crlf) begin
                                ck_hi_q <= hex_val;
                                state_q <= S_CK2;
                            end else begin
                                state_q     <= S_IDLE;
                                parse_err_q <= 1'b1;
                            end
                        end
                        S_CK2: begin
                            state_q <= S_IDLE;
                            if (!is_hex || is_crlf || !ck_match) begin
                                parse_err_q <= 1'b1;
                            end else if (fix_ok_q) begin
                                // A matching sentence without a fix is dropped silently
                                if (coord_ok[0] && coord_ok[1]) begin
                                    wei_q     <= coord_val[0];
                                    jing_q    <= coord_val[1];
                                    data_en_q <= 1'b1;
                                end else begin
                                    parse_err_q <= 1'b1;
                                end
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_gps_rmc_parser.sv
// tb_gps_rmc_parser: table-driven, hand-written and randomized checks of
// gps_rmc_parser against a string-level NMEA model.
module tb_gps_rmc_parser;

  logic        clk;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [16:0] wei_num;
  logic [16:0] jing_num;
  logic        data_en;
  logic        parse_err;

  gps_rmc_parser dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .wei_num   (wei_num),
    .jing_num  (jing_num),
    .data_en   (data_en),
    .parse_err (parse_err)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  // expected pulses: {kind[1:0] (1=data_en, 2=parse_err), wei[16:0], jing[16:0]}
  logic [35:0] exp_q[$];
  logic [16:0] cur_wei;
  logic [16:0] cur_jing;

  typedef struct {
    string       name;
    string       body;
    int          ck_mode;   // 0 correct upper, 1 wrong lower, 2 correct lower
    int          kind;      // 0 none, 1 data_en, 2 parse_err
    logic [16:0] wei;
    logic [16:0] jing;
  } vec_t;

  vec_t tv[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rx_valid = 1'b0;
      rx_data  = 8'($urandom_range(0, 255));
    end
  endtask

  function automatic logic [7:0] xsum(input string body);
    logic [7:0] x;
    x = 8'd0;
    for (int i = 0; i < body.len(); i++) x = x ^ body[i];
    return x;
  endfunction

  function automatic logic [7:0] hexch(input logic [3:0] n, input bit lower);
    string hx;
    if (lower) hx = "0123456789abcdef";
    else       hx = "0123456789ABCDEF";
    return hx[n];
  endfunction

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic send_sent(input string body, input logic [7:0] ck_xor, input bit lower, input bit crlf);
    logic [7:0] ck;
    ck = xsum(body) ^ ck_xor;
    send_byte(8'h24);
    send_str(body);
    send_byte(8'h2A);
    send_byte(hexch(ck[7:4], lower));
    send_byte(hexch(ck[3:0], lower));
    if (crlf) begin
      send_byte(8'h0D);
      send_byte(8'h0A);
    end
  endtask

  // ---------------- reference model ----------------
  // Coordinate field: "<int digits>.<frac digits>"; value = last two integer
  // digits as whole minutes and first three fraction digits as thousandths.
  function automatic bit coord(input string s, output logic [16:0] v);
    int dot;
    bit ok;
    int tens;
    int units;
    int frac;
    int w[3];
    dot = -1;
    ok = 1'b1;
    w[0] = 100; w[1] = 10; w[2] = 1;
    for (int i = 0; i < s.len(); i++) begin
      if (s[i] == 8'h2E) begin
        if (dot < 0) dot = i;
      end else if (s[i] < 8'h30 || s[i] > 8'h39) begin
        ok = 1'b0;
      end
    end
    v = 17'd0;
    if (dot < 1) ok = 1'b0;
    if (ok) begin
      tens  = (dot >= 2) ? int'(s[dot-2]) - 48 : 0;
      units = int'(s[dot-1]) - 48;
      frac  = 0;
      for (int k = 0; k < 3; k++)
        if (dot + 1 + k < s.len()) frac += (int'(s[dot+1+k]) - 48) * w[k];
      v = 17'(tens * 10000 + units * 1000 + frac);
    end
    return ok;
  endfunction

  task automatic model(input string body, input bit ck_good, output int kind,
                       output logic [16:0] lat, output logic [16:0] lon);
    string f[$];
    string cur;
    bit lat_ok;
    bit lon_ok;
    cur = "";
    for (int i = 0; i < body.len(); i++) begin
      if (body[i] == 8'h2C) begin
        f.push_back(cur);
        cur = "";
      end else begin
        cur = {cur, body.substr(i, i)};
      end
    end
    f.push_back(cur);
    kind = 0;
    lat = 17'd0;
    lon = 17'd0;
    if (f[0].len() == 5 && f[0].substr(2, 4) == "RMC") begin
      if (!ck_good) begin
        kind = 2;
      end else if (f.size() > 2 && f[2] == "A") begin
        lat_ok = (f.size() > 3) ? coord(f[3], lat) : 1'b0;
        lon_ok = (f.size() > 5) ? coord(f[5], lon) : 1'b0;
        kind = (lat_ok && lon_ok) ? 1 : 2;
      end
    end
  endtask

  function automatic string gen_digits(input int n);
    string digs;
    string s;
    int d;
    digs = "0123456789";
    s = "";
    for (int i = 0; i < n; i++) begin
      d = $urandom_range(0, 9);
      s = {s, digs.substr(d, d)};
    end
    return s;
  endfunction

  // mode 0 valid, 1 missing dot, 2 no integer digits, 3 illegal character
  function automatic string gen_coord(input int mode);
    string s;
    int ni;
    ni = (mode == 2) ? 0 : $urandom_range(1, 5);
    s = gen_digits(ni);
    if (mode != 1) s = {s, "."};
    s = {s, gen_digits($urandom_range(0, 5))};
    if (mode == 3) s = ($urandom_range(0, 1) == 1) ? {"-", s} : {s, "K"};
    return s;
  endfunction

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    logic [35:0] e;
    if (!rst && (data_en || parse_err)) begin
      if (data_en && parse_err) check("pulse_exclusive", 32'd1, 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", data_en ? 32'd1 : 32'd2, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("pulse_kind", data_en ? 32'd1 : 32'd2, 32'(e[35:34]));
        check("pulse_wei", 32'(wei_num), 32'(e[33:17]));
        check("pulse_jing", 32'(jing_num), 32'(e[16:0]));
      end
    end
  end

  task automatic expect_pulse(input int kind, input logic [16:0] w, input logic [16:0] j);
    if (kind != 0) exp_q.push_back({2'(kind), w, j});
  endtask

  task automatic add_vec(input string name, input string body, input int ck_mode, input int kind,
                         input logic [16:0] w, input logic [16:0] j);
    vec_t v;
    v.name = name; v.body = body; v.ck_mode = ck_mode; v.kind = kind; v.wei = w; v.jing = j;
    tv.push_back(v);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    string body;
    string tk[3];
    string status;
    int kind;
    int r;
    logic [16:0] lat;
    logic [16:0] lon;
    logic [7:0] ckx;

    rst = 1'b1;
    rx_valid = 1'b0;
    rx_data = 8'd0;
    cur_wei = 17'd0;
    cur_jing = 17'd0;
    #1;
    check("reset_wei", 32'(wei_num), 32'd0);
    check("reset_jing", 32'(jing_num), 32'd0);
    check("reset_data_en", 32'(data_en), 32'd0);
    check("reset_parse_err", 32'(parse_err), 32'd0);
    idle(2);
    rst = 1'b0;
    idle(2);

    // ---- table-driven vectors ----
    add_vec("base_accept", "GNRMC,083015.00,A,3018.76240,N,11307.67910,E,0.1,,130623,,,A", 0, 1, 18762, 7679);
    add_vec("bad_ck_lower", "GNRMC,083015.00,A,3018.76240,N,11307.67910,E,0.1,,130623,,,A", 1, 2, 18762, 7679);
    add_vec("status_v", "GNRMC,083016.00,V,3018.76240,N,11307.67910,E,0.1,,130623,,,N", 0, 0, 18762, 7679);
    add_vec("second_fix", "GPRMC,083017.00,A,3030.11,N,11312.95,E,,,,,,", 0, 1, 30110, 12950);
    add_vec("gga_ignored", "GPGGA,083015.00,3018.76240,N,11307.67910,E,1,08,0.9", 0, 0, 30110, 12950);
    add_vec("empty_lat", "GPRMC,083018.00,A,,N,11312.95,E,,,,,,", 0, 2, 30110, 12950);
    add_vec("bd_talker", "BDRMC,1,A,4501.5,S,00959.123456,W", 0, 1, 1500, 59123);
    add_vec("no_int_digits", "GNRMC,1,A,.5,N,11312.95,E", 0, 2, 1500, 59123);
    add_vec("no_dot", "GNRMC,1,A,3018,N,11312.95,E", 0, 2, 1500, 59123);
    add_vec("bad_char", "GNRMC,1,A,30X8.1,N,11312.95,E", 0, 2, 1500, 59123);
    add_vec("lon_invalid", "GNRMC,1,A,3018.1,N,113-12.95,E", 0, 2, 1500, 59123);
    add_vec("lower_ck_ok", "GPRMC,2,A,0000.000,N,12345.6,E", 2, 1, 0, 45600);
    add_vec("max_minutes", "GPRMC,3,A,9959.9999,N,17959.999,E", 0, 1, 59999, 59999);
    add_vec("empty_status", "GPRMC,4,,1111.111,N,2222.222,E", 0, 0, 59999, 59999);
    add_vec("short_fields", "GPRMC,5,A,7.,N,5.0,E", 0, 1, 7000, 5000);

    for (int i = 0; i < tv.size(); i++) begin
      expect_pulse(tv[i].kind, tv[i].wei, tv[i].jing);
      send_sent(tv[i].body, (tv[i].ck_mode == 1) ? 8'h5A : 8'h00, tv[i].ck_mode != 0, 1'b1);
      idle(3);
      check({tv[i].name, "_drained"}, 32'(exp_q.size()), 32'd0);
      check({tv[i].name, "_wei"}, 32'(wei_num), 32'(tv[i].wei));
      check({tv[i].name, "_jing"}, 32'(jing_num), 32'(tv[i].jing));
    end

    // ---- latency: pulse in the cycle after the second checksum character ----
    body = "GPRMC,6,A,4523.456,N,01234.567,E";
    expect_pulse(1, 23456, 34567);
    send_sent(body, 8'h00, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("lat_data_en_hi", 32'(data_en), 32'd1);
    check("lat_parse_err_lo", 32'(parse_err), 32'd0);
    check("lat_wei", 32'(wei_num), 32'd23456);
    check("lat_jing", 32'(jing_num), 32'd34567);
    rx_valid = 1'b0;
    @(posedge clk); #1;
    check("lat_data_en_width", 32'(data_en), 32'd0);
    idle(2);

    // ---- '$' injected mid-sentence, then a complete sentence ----
    send_str("$GPRMC,7,A,1234.5");
    expect_pulse(1, 11222, 22333);
    send_sent("GNRMC,8,A,1111.222,N,2222.333,E", 8'h00, 1'b0, 1'b1);
    idle(3);
    check("restart_drained", 32'(exp_q.size()), 32'd0);
    check("restart_wei", 32'(wei_num), 32'd11222);

    // ---- back-to-back sentences with continuous rx_valid ----
    expect_pulse(1, 1010, 2020);
    expect_pulse(1, 3030, 4040);
    send_sent("GPRMC,9,A,0101.010,N,0202.020,E", 8'h00, 1'b0, 1'b0);
    send_sent("GPRMC,9,A,0303.030,N,0404.040,E", 8'h00, 1'b1, 1'b0);
    idle(3);
    check("b2b_drained", 32'(exp_q.size()), 32'd0);
    check("b2b_jing", 32'(jing_num), 32'd4040);

    // ---- CR inside an RMC field aborts with parse_err ----
    expect_pulse(2, 3030, 4040);
    send_str("$GPRMC,10,A,12");
    send_byte(8'h0D);
    idle(3);
    check("crlf_drained", 32'(exp_q.size()), 32'd0);

    // ---- asynchronous reset mid-FIELD ----
    send_str("$GNRMC,11,A,45");
    @(negedge clk);
    rx_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("arst_wei", 32'(wei_num), 32'd0);
    check("arst_jing", 32'(jing_num), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    expect_pulse(1, 12345, 54321);
    send_sent("GNRMC,12,A,1212.345,N,05454.321,E", 8'h00, 1'b0, 1'b1);
    idle(3);
    check("post_rst_drained", 32'(exp_q.size()), 32'd0);
    check("post_rst_wei", 32'(wei_num), 32'd12345);
    cur_wei = 17'd12345;
    cur_jing = 17'd54321;

    // ---- randomized sentences against the string model ----
    tk[0] = "GP"; tk[1] = "GN"; tk[2] = "BD";
    for (int it = 0; it < 60; it++) begin
      r = $urandom_range(0, 9);
      status = (r < 7) ? "A" : ((r < 9) ? "V" : "");
      body = {tk[$urandom_range(0, 2)], ($urandom_range(0, 9) == 0) ? "GGA" : "RMC", ",",
              gen_digits(6), ",", status, ",",
              gen_coord(($urandom_range(0, 9) < 8) ? 0 : $urandom_range(1, 3)), ",N,",
              gen_coord(($urandom_range(0, 9) < 8) ? 0 : $urandom_range(1, 3)), ",E,0.5,,130623,,,A"};
      ckx = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      model(body, ckx == 8'h00, kind, lat, lon);
      if (kind == 1) begin
        cur_wei = lat;
        cur_jing = lon;
      end
      expect_pulse(kind, cur_wei, cur_jing);
      if ($urandom_range(0, 9) == 0) send_str({"$", body.substr(0, $urandom_range(0, 20))});
      send_sent(body, ckx, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
      if ($urandom_range(0, 2) == 0) begin
        idle($urandom_range(2, 4));
        check("rnd_drained", 32'(exp_q.size()), 32'd0);
        check("rnd_wei_hold", 32'(wei_num), 32'(cur_wei));
        check("rnd_jing_hold", 32'(jing_num), 32'(cur_jing));
      end
    end
    idle(4);
    check("final_drained", 32'(exp_q.size()), 32'd0);
    check("final_wei", 32'(wei_num), 32'(cur_wei));
    check("final_jing", 32'(jing_num), 32'(cur_jing));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/gps_rmc_parser.md
# gps_rmc_parser

Byte-stream parser that extracts position from NMEA RMC sentences delivered by the GPS UART receiver. It converts the latitude and longitude minute fields into 17-bit integers (`wei_num`, `jing_num`) and pulses `data_en` once per valid, checksum-correct, fixed sentence. It sits between the UART RX byte interface and the coordinate-scaling stage that maps `jing_num`/`wei_num` onto the 320×240 map.

## Interface
- No parameters.
- `clk` input 1: system clock.
- `rst` input 1: asynchronous, active-high reset.
- `rx_data` input 8: received ASCII byte.
- `rx_valid` input 1: one-cycle strobe, `rx_data` valid. Strobes may occur every cycle.
- `wei_num` output 17: latitude, minutes ×1000 (mm.mmm → mmmmm, 0–59999).
- `jing_num` output 17: longitude, same encoding.
- `data_en` output 1: one-cycle pulse when `wei_num`/`jing_num` have just been updated.
- `parse_err` output 1: one-cycle pulse when an RMC sentence is rejected for a checksum or format error.

## Operation
- Clock and reset: one clock (`clk`); reset `rst` is asynchronous and active-high.
- Bytes are processed only on cycles with `rx_valid`=1. All other cycles hold state.
- FSM states:
  - IDLE: wait for `$`; then clear the XOR checksum and go to HDR.
  - HDR: capture 5 header characters. Any talker is accepted (GP/GN/BD…). If chars 3–5 ≠ "RMC", go to IDLE silently. Otherwise expect `,` and go to FIELD with field index 1.
  - FIELD: each `,` increments the field index. `*` goes to CK1.
  - CK1: first checksum hex digit.
  - CK2: second checksum hex digit, then compare and go to IDLE.
- Checksum: XOR of every byte strictly between `$` and `*`. Hex digits are 0-9, A-F and a-f.
- A `$` received in any state restarts at HDR. The abandoned sentence is dropped with no `parse_err`.
- CR or LF seen in HDR/FIELD/CK1/CK2 aborts to IDLE. It pulses `parse_err` only if the header was RMC.
- Field 2 (status): `A` sets `fix_ok`; anything else, including empty, clears it.
- Fields 3 (lat, ddmm.mmmm) and 5 (lon, dddmm.mmmm) are extracted identically, with separate registers for each:
  - Digits before `.` shift through `tens`/`units`: `tens`←`units`, `units`←digit. Both are cleared at field start.
  - `.` sets `dot_seen`.
  - Fraction digits 1, 2 and 3 add digit×100, ×10 and ×1 to `frac` (10-bit). Further fraction digits are ignored.
  - Missing fraction digits count as 0.
  - Field value = `tens`×10000 + `units`×1000 + `frac`. It is computed at the end of the sentence and is 17-bit unsigned.
  - A field is valid only if `dot_seen` is set and at least one integer digit was seen.
  - Any non-digit byte other than `.` inside the field marks it invalid.
- Fields 4 and 6 (N/S, E/W) and all later fields are ignored, but they still enter the checksum.
- Accept condition at CK2: checksum match AND `fix_ok` AND lat valid AND lon valid.
  - Accept: load `wei_num`/`jing_num` and pulse `data_en`.
  - Checksum mismatch or invalid lat/lon: pulse `parse_err`; outputs unchanged.
  - `fix_ok`=0 with a matching checksum: no pulse, outputs unchanged.

## Timing
- Reset values: `wei_num`=0, `jing_num`=0, `data_en`=0, `parse_err`=0, FSM=IDLE, all internal registers 0.
- Latency: `data_en`/`parse_err` go high in the cycle after the `rx_valid` cycle carrying the second checksum character. In that same cycle `wei_num`/`jing_num` already show the new values.
- `data_en` and `parse_err` are exactly one cycle wide and never high together.
- Outputs are registered and hold between updates.
- Back-to-back sentences with zero idle cycles between `rx_valid` strobes must be parsed without loss.
- `rst` asserted mid-sentence: immediate return to reset values. The partial sentence is discarded, and the next `$` starts a fresh parse.

## Test plan
- `$GNRMC,083015.00,A,3018.76240,N,11307.67910,E,0.1,,130623,,,A*hh` with the bench-computed correct `hh` → one `data_en` pulse one cycle after the last `h`; `wei_num`=18762, `jing_num`=7679.
- Same sentence with a wrong checksum, in lowercase hex → `parse_err` pulse; outputs keep their previous values; no `data_en`.
- Status `V`, correct checksum → no `data_en` and no `parse_err`. Then a valid `A` sentence with lat `3030.11` and lon `11312.95` → `wei_num`=30110, `jing_num`=12950.
- `$GPGGA,…` with valid checksum → no pulses, outputs unchanged. `$GPRMC` with an empty lat field and correct checksum → `parse_err`.
- `$` injected halfway through an RMC sentence, followed by a complete valid sentence → exactly one `data_en` with the second sentence's values. Two valid sentences sent with continuous `rx_valid` → two `data_en` pulses.
- `rst` pulsed while in FIELD after a prior accept → outputs return to 0 asynchronously. The next valid sentence is accepted normally.
